alu_issue_buffer: RTL and testbench

Handshaked issue and result-buffer stage wrapped around the combinational `alu` datapath. It accepts operation commands over a valid/ready interface and drives the operands and select to the ALU in the same cycle. It captures `ALU_Result`/`Zero` with the command tag into an in-order FIFO and presents results downstream over a second valid/ready interface. It also keeps a saturating count of zero-result operations for debug.

---
 rtl/alu_issue_buffer.sv | 105 ++++++++++
 tb/tb_alu_issue_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_buffer.sv
// rtl/alu_issue_buffer.sv - handshaked issue stage and in-order result FIFO around an external ALU
//
// Purpose:
//   Accepts ALU commands over a valid/ready interface and drives the operands
//   straight to the parent-level ALU. In the same cycle it captures the ALU
//   result, the Zero flag and the command tag into an in-order FIFO. The FIFO
//   head is presented downstream over a second valid/ready interface. A
//   saturating counter records how many accepted operations produced Zero.
//
// Ports:
//   clk, rst_n                  clock; synchronous active-low reset
//   in_valid/in_ready           command handshake
//   in_a, in_b, in_sel, in_tag  command operands, op code and tag
//   alu_a, alu_b, alu_sel       combinational drive to the external ALU
//   alu_result, alu_zero        combinational return from the external ALU
//   out_valid/out_ready         result handshake
//   out_result/out_zero/out_tag head entry (zero when the FIFO is empty)
//   count                       FIFO occupancy
//   zero_cnt                    saturating count of accepted ops with Zero=1
module alu_issue_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_a,
  input  logic [DATA_WIDTH-1:0]      in_b,
  input  logic [2:0]                 in_sel,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic [DATA_WIDTH-1:0]      alu_a,
  output logic [DATA_WIDTH-1:0]      alu_b,
  output logic [2:0]                 alu_sel,
  input  logic [DATA_WIDTH-1:0]      alu_result,
  input  logic                       alu_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_result,
  output logic                       out_zero,
  output logic [TAG_WIDTH-1:0]       out_tag,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                zero_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_result [DEPTH];
  logic                  mem_zero   [DEPTH];
  logic [TAG_WIDTH-1:0]  mem_tag    [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push;
  logic             pop;

  // The ALU sits at the parent level; operands pass through unregistered so
  // its result is available for capture in the same cycle as the handshake.
  assign alu_a   = in_a;
  assign alu_b   = in_b;
  assign alu_sel = in_sel;

  // Accepting while full is safe when a pop frees the head slot this cycle.
  assign in_ready  = (count < CNT_W'(DEPTH)) || out_ready;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result = out_valid ? mem_result[head] : '0;
  assign out_zero   = out_valid ? mem_zero[head]   : 1'b0;
  assign out_tag    = out_valid ? mem_tag[head]    : '0;

  // Storage is not reset: entries are only visible through a nonzero count.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_result[tail] <= alu_result;
      mem_zero[tail]   <= alu_zero;
      mem_tag[tail]    <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      zero_cnt <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && alu_zero && (zero_cnt != 16'hFFFF)) begin
        zero_cnt <= zero_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_buffer.sv
// tb/tb_alu_issue_buffer.sv - directed self-checking bench for alu_issue_buffer
module tb_alu_issue_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_sel;
  logic [3:0]  in_tag;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [3:0]  out_tag;
  logic [2:0]  count;
  logic [15:0] zero_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_buffer #(.DATA_WIDTH(32), .DEPTH(4), .TAG_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .in_tag     (in_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_tag    (out_tag),
    .count      (count),
    .zero_cnt   (zero_cnt)
  );

  // Parent-level ALU model.
  always_comb begin
    alu_result = 32'd0;
    case (alu_sel)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = {31'd0, ($signed(alu_a) > $signed(alu_b))};
      3'd6: alu_result = {31'd0, (alu_a > alu_b)};
      3'd7: alu_result = {31'd0, (alu_a == alu_b)};
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] sel, input logic [3:0] tag);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sel   = sel;
    in_tag   = tag;
  endtask

  logic [31:0] sa;
  logic [31:0] sb;
  int          sent;
  int          rcvd;
  int          cycles;
  logic        fire_in;
  logic        fire_out;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sel    = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_zero_cnt", 32'(zero_cnt), 32'd0);

    // ADD 5+3, tag 1; no bypass so it shows the cycle after the push.
    drive(32'd5, 32'd3, 3'd0, 4'd1);
    check("alu_sel_wire", 32'(alu_sel), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_result", out_result, 32'd8);
    check("add_zero", 32'(out_zero), 32'd0);
    check("add_tag", 32'(out_tag), 32'd1);
    tick();
    check("add_count_after_pop", 32'(count), 32'd0);

    // SUB 7-7 yields Zero.
    drive(32'd7, 32'd7, 3'd1, 4'd2);
    tick();
    in_valid = 1'b0;
    #1;
    check("sub_result", out_result, 32'd0);
    check("sub_zero", 32'(out_zero), 32'd1);
    check("sub_tag", 32'(out_tag), 32'd2);
    check("sub_zero_cnt", 32'(zero_cnt), 32'd1);
    tick();

    // Signed GT (-1 > 1 false) then unsigned GTU (true), held in the FIFO.
    out_ready = 1'b0;
    drive(32'hFFFF_FFFF, 32'd1, 3'd5, 4'd3);
    tick();
    drive(32'hFFFF_FFFF, 32'd1, 3'd6, 4'd4);
    tick();
    in_valid = 1'b0;
    #1;
    check("gt_count", 32'(count), 32'd2);
    check("gt_result", out_result, 32'd0);
    check("gt_zero", 32'(out_zero), 32'd1);
    check("gt_tag", 32'(out_tag), 32'd3);
    check("gt_zero_cnt", 32'(zero_cnt), 32'd2);
    out_ready = 1'b1;
    tick();
    check("gtu_result", out_result, 32'd1);
    check("gtu_zero", 32'(out_zero), 32'd0);
    check("gtu_tag", 32'(out_tag), 32'd4);
    tick();
    check("gtu_drained", 32'(out_valid), 32'd0);

    // Fill to DEPTH, then push and pop in the same cycle while full.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'(i), 32'd10, 3'd0, 4'(i));
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head_tag", 32'(out_tag), 32'd0);
    drive(32'd4, 32'd10, 3'd0, 4'd4);
    out_ready = 1'b1;
    #1;
    check("full_in_ready_pop", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check("full_pushpop_count", 32'(count), 32'd4);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain_tag%0d", k), 32'(out_tag), 32'(k));
      check($sformatf("drain_res%0d", k), out_result, 32'(k + 10));
      tick();
    end
    check("drain_empty", 32'(count), 32'd0);
    check("drain_zero_cnt", 32'(zero_cnt), 32'd2);

    // Stream 20 XOR ops with a randomly stalling consumer.
    sent   = 0;
    rcvd   = 0;
    cycles = 0;
    while ((rcvd < 20) && (cycles < 600)) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        drive(32'hA5A5_0000 | 32'(sent), 32'h0F0F_0000 ^ 32'(sent * 3), 3'd4, 4'(sent));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        sa = 32'hA5A5_0000 | 32'(rcvd);
        sb = 32'h0F0F_0000 ^ 32'(rcvd * 3);
        check($sformatf("xor_res%0d", rcvd), out_result, sa ^ sb);
        check($sformatf("xor_tag%0d", rcvd), 32'(out_tag), 32'(rcvd % 16));
        rcvd++;
      end
      if (fire_in) sent++;
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    check("xor_received", 32'(rcvd), 32'd20);
    #1;
    check("xor_no_extra", 32'(out_valid), 32'd0);

    // Reset with three entries buffered and zero_cnt=2.
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b0;
    drive(32'd9, 32'd9, 3'd1, 4'd5);
    tick();
    drive(32'd1, 32'd2, 3'd7, 4'd6);
    tick();
    drive(32'd1, 32'd2, 3'd0, 4'd7);
    tick();
    in_valid = 1'b0;
    #1;
    check("pre_rst_count", 32'(count), 32'd3);
    check("pre_rst_zero_cnt", 32'(zero_cnt), 32'd2);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(32'd0, 32'd0, 3'd0, 4'd8);
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_zero_cnt", 32'(zero_cnt), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_tag", 32'(out_tag), 32'd0);
    tick();
    tick();
    check("post_rst_no_stale", 32'(out_valid), 32'd0);
    drive(32'd2, 32'd3, 3'd3, 4'd9);
    tick();
    in_valid = 1'b0;
    #1;
    check("post_rst_result", out_result, 32'd3);
    check("post_rst_tag", 32'(out_tag), 32'd9);
    tick();
    check("post_rst_empty", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
